// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters: rotating-priority pick, registered one-hot
// grant held until the requester drops or MAX_HOLD cycles elapse.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nx;
  logic [2:0]       ptr, ptr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       gnt_nx;
  logic [2:0]       idx_nx;
  logic             to_nx;
  logic [2:0]       win_idx;
  logic             win_vld;

  // Circular search from ptr; walking offsets high-to-low lets offset 0 win last.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (req[ptr + 3'(k)]) begin
        win_idx = ptr + 3'(k);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    idx_nx   = gnt_idx;
    to_nx    = 1'b0;
    if (!en) begin
      // Disable drops the grant but keeps ptr so priority survives the pause.
      state_nx = IDLE;
      cnt_nx   = '0;
      gnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          gnt_nx = '0;
          idx_nx = '0;
          if (win_vld) begin
            state_nx = GRANT;
            gnt_nx   = 8'd1 << win_idx;
            idx_nx   = win_idx;
            cnt_nx   = '0;
          end
        end
        GRANT: begin
          if (!req[gnt_idx] || cnt == CNT_W'(MAX_HOLD - 1)) begin
            state_nx = IDLE;
            gnt_nx   = '0;
            idx_nx   = '0;
            cnt_nx   = '0;
            ptr_nx   = gnt_idx + 3'd1;
            to_nx    = req[gnt_idx];
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      cnt       <= cnt_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= |gnt_nx;
      timeout   <= to_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed vector table, hand sequences, and random traffic
// against an owner/hold-count reference model.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk, rst_n, en;
  logic [7:0] req;
  logic [7:0] gnt, gnt1;
  logic [2:0] gnt_idx, gnt_idx1;
  logic       gnt_valid, gnt_valid1, timeout, timeout1;

  int passed = 0;
  int total  = 0;

  rr_arbiter8 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout));

  rr_arbiter8 #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_valid(gnt_valid1), .timeout(timeout1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: who owns the resource, how many cycles it has been visible, next priority.
  int m_own, m_ptr, m_held;
  bit m_to;

  always @(posedge clk or negedge rst_n) begin
    int o, p, h;
    bit t, found;
    if (!rst_n) begin
      m_own <= -1; m_ptr <= 0; m_held <= 0; m_to <= 1'b0;
    end else begin
      o = m_own; p = m_ptr; h = m_held; t = 1'b0; found = 1'b0;
      if (!en) o = -1;
      else if (o < 0) begin
        for (int k = 0; k < 8; k++)
          if (!found && req[(p + k) % 8]) begin
            o = (p + k) % 8; h = 1; found = 1'b1;
          end
      end else if (!req[o]) begin
        p = (o + 1) % 8; o = -1;
      end else if (h == MH) begin
        p = (o + 1) % 8; o = -1; t = 1'b1;
      end else h = h + 1;
      m_own <= o; m_ptr <= p; m_held <= h; m_to <= t;
    end
  end

  task automatic chk(input string name,
                     input logic [7:0] ag, input logic [2:0] ai, input logic av, input logic at,
                     input logic [7:0] eg, input logic [2:0] ei, input logic ev, input logic et);
    total++;
    if (ag !== eg || ai !== ei || av !== ev || at !== et)
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
               name, ag, ai, av, at, eg, ei, ev, et);
    else passed++;
  endtask

  task automatic step(input logic e, input logic [7:0] r);
    en = e; req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; req = 8'hFF;
    repeat (3) @(negedge clk);
    chk("reset", gnt, gnt_idx, gnt_valid, timeout, 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t tbl[25];

  initial begin
    logic [7:0] eg;
    logic [7:0] r;
    logic       e;
    rst_n = 1'b1; en = 1'b0; req = 8'h00;
    @(negedge clk);

    do_reset();

    // Constant full request: each grant lasts MH cycles, then a timeout gap.
    // The MAX_HOLD=1 instance alternates single-cycle grants and timeout gaps.
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < MH + 1; c++) begin
        int n;
        step(1'b1, 8'hFF);
        if (c < MH) begin
          eg = 8'd1 << (g % 8);
          chk("fair_hold", gnt, gnt_idx, gnt_valid, timeout, eg, 3'(g % 8), 1'b1, 1'b0);
        end else
          chk("fair_gap", gnt, gnt_idx, gnt_valid, timeout, 8'h00, 3'd0, 1'b0, 1'b1);
        n = g * (MH + 1) + c;
        if (n % 2 == 0) begin
          eg = 8'd1 << ((n / 2) % 8);
          chk("mh1_grant", gnt1, gnt_idx1, gnt_valid1, timeout1, eg, 3'((n / 2) % 8), 1'b1, 1'b0);
        end else
          chk("mh1_gap", gnt1, gnt_idx1, gnt_valid1, timeout1, 8'h00, 3'd0, 1'b0, 1'b1);
      end
    end

    // Asynchronous reset in the middle of a cycle while a grant is active.
    #1 rst_n = 1'b0;
    #1 chk("async_reset", gnt, gnt_idx, gnt_valid, timeout, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    //            en    req    gnt    idx  vld to
    tbl[0]  = '{1'b1, 8'h90, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h08, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h08, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'h09, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 8'h08, 8'h00, 3'd0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 8'h25, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 8'h25, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 8'h04, 8'h00, 3'd0, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[22] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[23] = '{1'b1, 8'h09, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[24] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].en, tbl[i].req);
      chk($sformatf("vec%0d", i), gnt, gnt_idx, gnt_valid, timeout,
          tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].to);
    end

    // Random traffic with sticky request patterns so holds reach MAX_HOLD.
    r = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      e = ($urandom_range(0, 9) != 0);
      step(e, r);
      eg = (m_own >= 0) ? (8'd1 << m_own) : 8'h00;
      chk("random", gnt, gnt_idx, gnt_valid, timeout,
          eg, (m_own >= 0) ? 3'(m_own) : 3'd0, (m_own >= 0), m_to);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
